// File: rtl/pipe_ctrl.sv
// Central pipeline control: priority resolution of freeze / redirect / flush bubbles / hazard stall,
// stall watchdog, and optional performance counters built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int WDOG_LIMIT   = 255,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hz_stall_req,
   input  logic             ex_jump_req,
   input  logic [31:0]      ex_jump_addr,
   input  logic             mem_busy,
   output logic             hold_pc,
   output logic             hold_if_id,
   output logic             hold_id_ex,
   output logic             hold_ex_mem,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             jump_o,
   output logic [31:0]      jump_addr_o,
   output logic             wdog_err,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt,
   output logic [CNT_W-1:0] perf_freeze_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      FREEZE = 2'd2
   } state_t;

   localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
   localparam logic [15:0] WDOG_MAX   = 16'(WDOG_LIMIT);

   state_t      state_r;
   logic [2:0]  flush_left_r;
   logic [15:0] wdog_cnt_r;
   logic        wdog_err_r;
   logic        freeze_s;
   logic        redirect_s;
   logic        bubble_s;
   logic        any_hold_s;

   // Priority decode of the current cycle into stage controls
   always_comb begin
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      hold_ex_mem = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      jump_o      = 1'b0;
      freeze_s    = 1'b0;
      redirect_s  = 1'b0;
      bubble_s    = 1'b0;
      if (!rst) begin
         freeze_s = 1'b0;
      end else if (mem_busy) begin
         // EX is frozen, so a pending jump is simply re-presented after the freeze
         hold_pc     = 1'b1;
         hold_if_id  = 1'b1;
         hold_id_ex  = 1'b1;
         hold_ex_mem = 1'b1;
         freeze_s    = 1'b1;
      end else if (ex_jump_req) begin
         jump_o      = 1'b1;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
         redirect_s  = 1'b1;
      end else if ((state_r != RUN) && (flush_left_r != 3'd0)) begin
         flush_if_id = 1'b1;
         bubble_s    = 1'b1;
      end else if (hz_stall_req) begin
         hold_pc     = 1'b1;
         hold_if_id  = 1'b1;
         flush_id_ex = 1'b1;
      end else begin
         bubble_s = 1'b0;
      end
   end

   assign jump_addr_o = jump_o ? ex_jump_addr : 32'h0000_0000;
   assign any_hold_s  = hold_pc | hold_if_id | hold_id_ex | hold_ex_mem;
   assign wdog_err    = rst & wdog_err_r;

   // State, remaining bubbles and stall watchdog
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= RUN;
         flush_left_r <= 3'd0;
         wdog_cnt_r   <= 16'd0;
         wdog_err_r   <= 1'b0;
      end else begin
         if (freeze_s) begin
            state_r <= FREEZE;
         end else if (redirect_s) begin
            flush_left_r <= FLUSH_INIT;
            state_r      <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
         end else if (bubble_s) begin
            flush_left_r <= flush_left_r - 3'd1;
            state_r      <= (flush_left_r == 3'd1) ? RUN : FLUSH;
         end else begin
            state_r <= RUN;
         end

         if (any_hold_s) begin
            if (wdog_cnt_r < WDOG_MAX) begin
               wdog_cnt_r <= wdog_cnt_r + 16'd1;
            end
            if (wdog_cnt_r >= (WDOG_MAX - 16'd1)) begin
               wdog_err_r <= 1'b1;
            end
         end else begin
            wdog_cnt_r <= 16'd0;
         end
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;
   logic [CNT_W-1:0] freeze_cnt_r;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Saturating event counters; a hazard stall is a hold that is not a freeze
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_r  <= {CNT_W{1'b0}};
         flush_cnt_r  <= {CNT_W{1'b0}};
         freeze_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (hold_pc && !freeze_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end
         if (redirect_s) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
         end
         if (freeze_s) begin
            freeze_cnt_r <= sat_inc(freeze_cnt_r);
         end
      end
   end

   assign perf_stall_cnt  = rst ? stall_cnt_r  : {CNT_W{1'b0}};
   assign perf_flush_cnt  = rst ? flush_cnt_r  : {CNT_W{1'b0}};
   assign perf_freeze_cnt = rst ? freeze_cnt_r : {CNT_W{1'b0}};
`else
   assign perf_stall_cnt  = {CNT_W{1'b0}};
   assign perf_flush_cnt  = {CNT_W{1'b0}};
   assign perf_freeze_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control for the five-stage RISC-V core. Consumes `stall_req` from the hazard detection unit, the EX-stage jump/branch redirect and the MEM-stage busy signal. Resolves them by priority into per-stage hold/flush controls and the PC redirect. It also tracks post-redirect flush bubbles, guards against stall deadlock with a watchdog, and optionally counts pipeline events.

## Interface
- `FLUSH_CYCLES`, default 2: IF/ID flush cycles per redirect, including the redirect cycle itself; legal range 1..7.
- `WDOG_LIMIT`, default 255: number of consecutive hold cycles that sets `wdog_err`; legal range 1..65535.
- `CNT_W`, default 32: width of the performance counters.

- `clk` input 1: core clock.
- `rst` input 1: reset; synchronous, active-low.
- `hz_stall_req` input 1: load-use/RAW stall request from the hazard detection unit.
- `ex_jump_req` input 1: taken branch or jump resolved in EX.
- `ex_jump_addr` input 32: redirect target.
- `mem_busy` input 1: MEM stage multi-cycle access in progress.
- `hold_pc` output 1: PC keeps its value.
- `hold_if_id` output 1: IF/ID register keeps its value.
- `hold_id_ex` output 1: ID/EX register keeps its value.
- `hold_ex_mem` output 1: EX/MEM register keeps its value.
- `flush_if_id` output 1: IF/ID loads a NOP.
- `flush_id_ex` output 1: ID/EX loads a NOP (bubble).
- `jump_o` output 1: PC loads `jump_addr_o`.
- `jump_addr_o` output 32: redirect target; equals `ex_jump_addr` when `jump_o` = 1, otherwise 0.
- `wdog_err` output 1: sticky deadlock flag.
- `perf_stall_cnt` output CNT_W: number of hazard-stall cycles.
- `perf_flush_cnt` output CNT_W: number of redirects taken.
- `perf_freeze_cnt` output CNT_W: number of `mem_busy` freeze cycles.

## Operation
States:
- `RUN`: normal operation.
- `FLUSH`: flush bubbles remaining after a redirect.
- `FREEZE`: `mem_busy` in effect.

Registered state:
- `state`
- `flush_left` (3 bit)
- `wdog_cnt` (16 bit)
- `wdog_err`
- the performance counters

Combinational outputs are derived from the current state and the current inputs, in priority order:
1. **`rst` = 0:** every output is 0.
2. **`mem_busy` = 1, freeze:** `hold_pc`, `hold_if_id`, `hold_id_ex` and `hold_ex_mem` are all 1. No flush. `jump_o` = 0; `ex_jump_req` is ignored because EX is frozen, and the request is presented again once the freeze ends. `state` becomes `FREEZE`, and `flush_left` is preserved.
3. **`ex_jump_req` = 1, redirect:** `jump_o`, `flush_if_id` and `flush_id_ex` are 1, and all holds are 0.
   - `flush_left` loads FLUSH_CYCLES−1.
   - `state` becomes `FLUSH` if FLUSH_CYCLES > 1, otherwise `RUN`.
   - A new redirect while already in `FLUSH` restarts the count.
4. **`state` = `FLUSH` (with `flush_left` > 0), or `FREEZE` resuming with `flush_left` > 0:** `flush_if_id` = 1. `hz_stall_req` is ignored because the ID instruction is being discarded. `flush_left` decrements, and the state returns to `RUN` when it reaches 0.
5. **`hz_stall_req` = 1:** `hold_pc` = 1, `hold_if_id` = 1 and `flush_id_ex` = 1. EX and MEM advance.
6. **Otherwise:** all control outputs are 0.

When leaving `FREEZE`, the next state is `FLUSH` if `flush_left` ≠ 0, otherwise `RUN`.

Watchdog:
- `wdog_cnt` increments on every cycle in which any hold output is 1, saturating at WDOG_LIMIT.
- It clears to 0 on any cycle with no hold asserted.
- `wdog_err` is set on the cycle in which `wdog_cnt` reaches WDOG_LIMIT, and is cleared only by reset.
- The watchdog does not alter pipeline control.

## Timing
- Every control output is combinational, with zero-cycle latency from its inputs; the stage registers sample it on the next edge.
- A redirect in cycle N produces `flush_if_id` = 1 in cycles N through N+FLUSH_CYCLES−1, excluding any frozen cycles.
- Reset takes effect on the clock edge with `rst` = 0. The state, counters, `wdog_cnt` and `wdog_err` all go to 0/`RUN`. A reset during `FLUSH` or `FREEZE` abandons the remaining bubbles.
- Simultaneous `mem_busy`, `ex_jump_req` and `hz_stall_req`: the freeze takes priority and the redirect occurs on the first cycle with `mem_busy` = 0.
- The performance counters saturate at all-ones and never wrap.

## Configuration
- **`PIPE_PERF_CNT_EN` defined:**
  - `perf_stall_cnt` increments on each cycle with priority-5 behaviour.
  - `perf_flush_cnt` increments on each redirect cycle.
  - `perf_freeze_cnt` increments on each freeze cycle.
  - All three are cleared by reset.
- **Not defined:** the counter registers are not built, and all three ports are tied to 0.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles with every input = 1 → all outputs are 0 throughout. After release with inputs at 0 → state `RUN` and all outputs 0.
- **Hazard stall:** `hz_stall_req` = 1 for 2 cycles → `hold_pc`, `hold_if_id` and `flush_id_ex` are 1 for exactly those 2 cycles, with `hold_ex_mem` = 0.
- **Redirect:** FLUSH_CYCLES = 2 and `ex_jump_req` = 1 with `ex_jump_addr` = 0x0000_0100 for 1 cycle → `jump_o` = 1 and `jump_addr_o` = 0x100 in cycle N; `flush_if_id` = 1 in cycles N and N+1; `hz_stall_req` = 1 in cycle N+1 is ignored.
- **Freeze over jump:** `mem_busy` = 1 for 3 cycles while `ex_jump_req` = 1 → all four holds are 1 and `jump_o` = 0 during those cycles; `jump_o` = 1 in the cycle after `mem_busy` falls.
- **Watchdog:** WDOG_LIMIT = 4, `hz_stall_req` held at 1 → `wdog_err` rises on the 4th stall cycle. After `hz_stall_req` drops it stays 1, and it clears only on reset.
- **Counters (macro defined):** 3 stall cycles, 2 redirects and 5 freeze cycles → `perf_stall_cnt` = 3, `perf_flush_cnt` = 2, `perf_freeze_cnt` = 5. Without the macro, all three read 0.
